// File: rtl/kernel_if_pkg.sv
// Shared definitions for initiators of start/finish kernels produced by the
// HLS flow: invoker FSM states, default widths and the response record.
// No ports (package).
package kernel_if_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        LAUNCH,
        WAIT,
        RESP
    } kstate_e;

    // Response record at the default widths. Invokers built with other
    // widths declare the same field layout locally.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] ret;
        logic                  err;
        logic [DEF_CNT_W-1:0]  cycles;
    } kresp_t;

endpackage

// File: rtl/collatz_invoker.sv
// Caller side of a scalar-argument / scalar-return start/finish kernel.
// Per accepted request: hold the callee in reset for RST_CYCLES, pulse start
// for one cycle, wait for finish (or TIMEOUT), then present the result on a
// valid/ready response stream. One invocation in flight at a time.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready/req_arg request stream (argument)
//   resp_valid/resp_ready       response stream handshake
//   resp_ret/resp_err/resp_cycles  return value, timeout flag, latency
//   callee_rst_n/start/arg      drive to the kernel instance
//   callee_finish/callee_ret    status from the kernel instance
module collatz_invoker
    import kernel_if_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1048576,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_arg,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_ret,
    output logic              resp_err,
    output logic [CNT_W-1:0]  resp_cycles,
    output logic              callee_rst_n,
    output logic              callee_start,
    output logic [DATA_W-1:0] callee_arg,
    input  logic              callee_finish,
    input  logic [DATA_W-1:0] callee_ret
);

    typedef struct packed {
        logic [DATA_W-1:0] ret;
        logic              err;
        logic [CNT_W-1:0]  cycles;
    } resp_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_CYC   = CNT_W'(TIMEOUT);

    kstate_e           state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;     // CRST length, then latency/timeout
    logic [DATA_W-1:0] arg_q;
    resp_t             resp_q, resp_nx;
    logic              accept;

    assign accept = (state == IDLE) && req_valid && req_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        resp_nx  = resp_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CRST;
                    cnt_nx   = '0;
                end
            end
            CRST: begin
                if (cnt == RST_LAST) begin
                    state_nx = LAUNCH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            LAUNCH: begin
                // counter is 0 during the launch cycle
                state_nx = WAIT;
                cnt_nx   = cnt + 1'b1;
            end
            WAIT: begin
                // finish takes priority over a timeout in the same cycle
                if (callee_finish) begin
                    state_nx = RESP;
                    resp_nx  = '{ret: callee_ret, err: 1'b0, cycles: cnt};
                end else if (cnt >= TO_LAST) begin
                    state_nx = RESP;
                    resp_nx  = '{ret: '0, err: 1'b1, cycles: TO_CYC};
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake/callee controls are registered from the next state so they
    // line up with the state register and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            arg_q        <= '0;
            resp_q       <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            callee_rst_n <= 1'b0;
            callee_start <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            resp_q       <= resp_nx;
            if (accept) arg_q <= req_arg;
            req_ready    <= (state_nx == IDLE);
            resp_valid   <= (state_nx == RESP);
            // idle callee stays held in reset; released from launch onward
            callee_rst_n <= (state_nx == LAUNCH) || (state_nx == WAIT) ||
                            (state_nx == RESP);
            callee_start <= (state_nx == LAUNCH);
        end
    end

    assign callee_arg  = arg_q;
    assign resp_ret    = resp_q.ret;
    assign resp_err    = resp_q.err;
    assign resp_cycles = resp_q.cycles;

endmodule

// File: tb/tb_collatz_invoker.sv
// Self-checking bench for collatz_invoker. Instance 1 drives a Collatz callee
// (default TIMEOUT), instance 2 drives a stub callee with TIMEOUT=64 whose
// finish time is programmable.
module tb_collatz_invoker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // instance 1 signals
    logic        req_valid1 = 1'b0, req_ready1, resp_valid1, resp_ready1 = 1'b0;
    logic [31:0] req_arg1 = '0, resp_ret1, resp_cycles1, carg1, cret1;
    logic        resp_err1, crst_n1, cstart1, cfin1;
    // instance 2 signals
    logic        req_valid2 = 1'b0, req_ready2, resp_valid2, resp_ready2 = 1'b0;
    logic [31:0] req_arg2 = '0, resp_ret2, resp_cycles2, carg2, cret2;
    logic        resp_err2, crst_n2, cstart2, cfin2;

    collatz_invoker #(.DATA_W(32), .RST_CYCLES(2), .TIMEOUT(1048576), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_arg(req_arg1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_ret(resp_ret1),
        .resp_err(resp_err1), .resp_cycles(resp_cycles1),
        .callee_rst_n(crst_n1), .callee_start(cstart1), .callee_arg(carg1),
        .callee_finish(cfin1), .callee_ret(cret1)
    );

    collatz_invoker #(.DATA_W(32), .RST_CYCLES(2), .TIMEOUT(64), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_arg(req_arg2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_ret(resp_ret2),
        .resp_err(resp_err2), .resp_cycles(resp_cycles2),
        .callee_rst_n(crst_n2), .callee_start(cstart2), .callee_arg(carg2),
        .callee_finish(cfin2), .callee_ret(cret2)
    );

    // Collatz callee: one step per cycle after start, finish sticky until reset
    logic [31:0] cn, csteps;
    logic        cbusy, cdone;
    always @(posedge clk) begin
        if (!crst_n1) begin
            cn <= carg1; csteps <= '0; cbusy <= 1'b0; cdone <= 1'b0;
        end else if (cstart1) begin
            cbusy <= 1'b1;
        end else if (cbusy && !cdone) begin
            if (cn == 32'd1) cdone <= 1'b1;
            else begin
                cn     <= cn[0] ? cn * 32'd3 + 32'd1 : cn >> 1;
                csteps <= csteps + 32'd1;
            end
        end
    end
    assign cfin1 = cdone;
    assign cret1 = csteps;

    // Stub callee: finish once stub_d cycles have elapsed since start (0 = never)
    int          stub_d = 0;
    logic        busy2;
    logic [31:0] c2;
    always @(posedge clk) begin
        if (!crst_n2) begin
            busy2 <= 1'b0; c2 <= '0;
        end else if (cstart2) begin
            busy2 <= 1'b1; c2 <= 32'd1;
        end else if (busy2) begin
            c2 <= c2 + 32'd1;
        end
    end
    assign cfin2 = busy2 && (stub_d != 0) && (c2 >= 32'(stub_d));
    assign cret2 = 32'hABCD;

    // Monitor on instance 1 callee controls
    bit mon_en = 1'b0;
    int low_cnt = 0, start_cnt = 0, rise_cnt = 0;
    logic prev_rn = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !crst_n1) low_cnt <= low_cnt + 1;
        if (mon_en && cstart1) start_cnt <= start_cnt + 1;
        prev_rn <= crst_n1;
        if (crst_n1 && !prev_rn) rise_cnt <= rise_cnt + 1;
    end

    // Instance selection for the generic request driver
    int cur = 0;
    wire        rr_s  = (cur != 0) ? req_ready2   : req_ready1;
    wire        rv_s  = (cur != 0) ? resp_valid2  : resp_valid1;
    wire [31:0] ret_s = (cur != 0) ? resp_ret2    : resp_ret1;
    wire        err_s = (cur != 0) ? resp_err2    : resp_err1;
    wire [31:0] cyc_s = (cur != 0) ? resp_cycles2 : resp_cycles1;

    task automatic drive_req(input logic v, input logic [31:0] a);
        if (cur != 0) begin req_valid2 = v; req_arg2 = a; end
        else begin req_valid1 = v; req_arg1 = a; end
    endtask

    task automatic drive_rr(input logic v);
        if (cur != 0) resp_ready2 = v; else resp_ready1 = v;
    endtask

    // Reference: number of Collatz steps to reach 1
    function automatic int unsigned collatz_steps(input int unsigned n);
        int unsigned k = 0;
        while (n != 1) begin
            n = (n % 2 == 1) ? 3 * n + 1 : n / 2;
            k++;
        end
        return k;
    endfunction

    // One request on the selected instance; response held back for bp cycles.
    task automatic run_req(input logic [31:0] a, input int bp,
                           output logic [31:0] r, output logic e, output logic [31:0] cy,
                           output bit ok, output bit hold_ok);
        bit got = 1'b0;
        ok = 1'b0; hold_ok = 1'b1; r = '0; e = 1'b0; cy = '0;
        for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = rr_s; end
        if (!got) return;
        drive_req(1'b1, a);
        @(posedge clk); #1;
        drive_req(1'b0, '0);
        mon_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            got = rv_s;
            if (!got && rr_s) hold_ok = 1'b0;
        end
        mon_en = 1'b0;
        if (!got) return;
        r = ret_s; e = err_s; cy = cyc_s;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!rv_s || ret_s !== r || err_s !== e || cyc_s !== cy || rr_s) hold_ok = 1'b0;
        end
        drive_rr(1'b1);
        @(posedge clk); #1;
        drive_rr(1'b0);
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({req_ready1, resp_valid1, resp_err1, crst_n1, cstart1} !== 5'b0 ||
            resp_ret1 !== '0 || resp_cycles1 !== '0 || carg1 !== '0) begin
            errors++;
            $display("FAIL reset_vals1 got rdy=%b vld=%b err=%b rstn=%b start=%b ret=%0d cyc=%0d arg=%0d want all 0",
                     req_ready1, resp_valid1, resp_err1, crst_n1, cstart1, resp_ret1, resp_cycles1, carg1);
        end
        tests++;
        if ({req_ready2, resp_valid2, crst_n2, cstart2} !== 4'b0) begin
            errors++;
            $display("FAIL reset_vals2 got rdy=%b vld=%b rstn=%b start=%b want 0", req_ready2, resp_valid2, crst_n2, cstart2);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready1 !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge got %b want 0", req_ready1);
        end
        @(negedge clk);
        tests++;
        if (req_ready1 !== 1'b1 || crst_n1 !== 1'b0) begin
            errors++; $display("FAIL ready_after_rst got rdy=%b rstn=%b want rdy=1 rstn=0", req_ready1, crst_n1);
        end
    endtask

    task automatic test_collatz6();
        logic [31:0] r, cy; logic e; bit ok, hold;
        int l0, s0;
        cur = 0;
        l0 = low_cnt; s0 = start_cnt;
        run_req(32'd6, 0, r, e, cy, ok, hold);
        tests++;
        if (!ok || r !== 32'd8 || e !== 1'b0) begin
            errors++; $display("FAIL collatz6 got ok=%b ret=%0d err=%b want ret=8 err=0", ok, r, e);
        end
        tests++;
        if (cy !== 32'd10) begin
            errors++; $display("FAIL collatz6_cycles got %0d want 10", cy);
        end
        tests++;
        if (low_cnt - l0 != 2 || start_cnt - s0 != 1) begin
            errors++; $display("FAIL collatz6_ctrl got rst_low=%0d start_hi=%0d want 2 and 1", low_cnt - l0, start_cnt - s0);
        end
        tests++;
        if (!hold) begin
            errors++; $display("FAIL collatz6_ready got req_ready high while busy want low");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] args [3];
        logic [31:0] exp  [3];
        int acc = 0, got = 0, r0;
        bit acc_hs, resp_hs;
        args = '{32'd1, 32'd27, 32'd7};
        exp  = '{32'd0, 32'd111, 32'd16};
        cur = 0;
        r0 = rise_cnt;
        req_valid1 = 1'b1; req_arg1 = args[0]; resp_ready1 = 1'b1;
        for (int cyc = 0; cyc < 3000 && got < 3; cyc++) begin
            @(negedge clk);
            acc_hs  = req_valid1 && req_ready1;
            resp_hs = resp_valid1 && resp_ready1;
            if (resp_hs) begin
                tests++;
                if (resp_ret1 !== exp[got] || resp_err1 !== 1'b0) begin
                    errors++; $display("FAIL b2b_ret[%0d] got %0d err=%b want %0d", got, resp_ret1, resp_err1, exp[got]);
                end
                got++;
            end
            if (acc_hs) begin
                tests++;
                if (acc != got) begin
                    errors++; $display("FAIL b2b_overlap got accept %0d with %0d responses want %0d", acc, got, acc);
                end
                acc++;
            end
            @(posedge clk); #1;
            if (acc_hs) begin
                if (acc < 3) req_arg1 = args[acc];
                else req_valid1 = 1'b0;
            end
        end
        req_valid1 = 1'b0; resp_ready1 = 1'b0;
        tests++;
        if (got != 3 || rise_cnt - r0 != 3) begin
            errors++; $display("FAIL b2b_count got resp=%0d launches=%0d want 3 and 3", got, rise_cnt - r0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, cy; logic e; bit ok, hold;
        cur = 0;
        run_req(32'd6, 10, r, e, cy, ok, hold);
        tests++;
        if (!ok || r !== 32'd8 || !hold) begin
            errors++; $display("FAIL backpressure got ok=%b ret=%0d stable=%b want ret=8 stable=1", ok, r, hold);
        end
        @(negedge clk);
        tests++;
        if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
            errors++; $display("FAIL bp_idle got rdy=%b vld=%b want 1 0", req_ready1, resp_valid1);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] r, cy; logic e; bit ok, hold;
        int d;
        cur = 1;
        stub_d = 0;
        run_req(32'd5, 2, r, e, cy, ok, hold);
        tests++;
        if (!ok || e !== 1'b1 || r !== 32'd0 || cy !== 32'd64) begin
            errors++; $display("FAIL timeout got ok=%b err=%b ret=%0d cyc=%0d want 1 0 64", ok, e, r, cy);
        end
        @(negedge clk);
        tests++;
        if (req_ready2 !== 1'b1) begin
            errors++; $display("FAIL timeout_idle got rdy=%b want 1", req_ready2);
        end
        // finish exactly on the last waiting cycle beats the timeout
        stub_d = 63;
        run_req(32'd9, 0, r, e, cy, ok, hold);
        tests++;
        if (!ok || e !== 1'b0 || r !== 32'hABCD || cy !== 32'd63) begin
            errors++; $display("FAIL finish_on_timeout got err=%b ret=%h cyc=%0d want 0 abcd 63", e, r, cy);
        end
        d = $urandom_range(1, 62);
        stub_d = d;
        run_req(32'd3, 1, r, e, cy, ok, hold);
        tests++;
        if (!ok || e !== 1'b0 || r !== 32'hABCD || cy !== 32'(d)) begin
            errors++; $display("FAIL stub_finish got err=%b ret=%h cyc=%0d want 0 abcd %0d", e, r, cy, d);
        end
        stub_d = 0;
        cur = 0;
    endtask

    task automatic test_random();
        logic [31:0] r, cy; logic e; bit ok, hold;
        int unsigned a, k;
        cur = 0;
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(1, 1000);
            k = collatz_steps(a);
            run_req(a, $urandom_range(0, 3), r, e, cy, ok, hold);
            tests++;
            if (!ok || !hold || e !== 1'b0 || r !== k || cy !== k + 2) begin
                errors++;
                $display("FAIL random_%0d arg=%0d got ok=%b hold=%b err=%b ret=%0d cyc=%0d want ret=%0d cyc=%0d",
                         i, a, ok, hold, e, r, cy, k, k + 2);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] r, cy; logic e; bit ok, hold, seen = 1'b0, bad = 1'b0;
        cur = 0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = req_ready1; end
        req_valid1 = 1'b1; req_arg1 = 32'd27;
        @(posedge clk); #1 req_valid1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = cstart1; end
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (!seen || crst_n1 !== 1'b0 || req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
            errors++; $display("FAIL rst_mid got started=%b rstn=%b rdy=%b vld=%b want 1 0 1 0", seen, crst_n1, req_ready1, resp_valid1);
        end
        repeat (200) begin @(negedge clk); if (resp_valid1) bad = 1'b1; end
        tests++;
        if (bad) begin
            errors++; $display("FAIL rst_mid_noresp got resp_valid=1 want 0");
        end
        run_req(32'd6, 0, r, e, cy, ok, hold);
        tests++;
        if (!ok || r !== 32'd8 || e !== 1'b0) begin
            errors++; $display("FAIL rst_mid_rerun got ok=%b ret=%0d err=%b want 8 0", ok, r, e);
        end
    endtask

    initial begin
        test_reset();
        test_collatz6();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_random();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want summary before time limit");
        $fatal(1, "watchdog");
    end

endmodule
